inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
Encodes RV32I instruction requests (class, register indices, funct fields, immediate) into 32-bit instruction words. It writes them sequentially into instruction memory through a single write port. It is the producer side of the opcode-to-control path: it generates the opcodes 0110011, 0010011, 0000011, 0100011 and 1100011 that the main control decoder consumes. It sits between the test/boot loader front end and the instruction memory.

Parameters:
ADDR_W, 6, width of the imem word address.
MEM_WORDS, 64, number of writable words; must be at most 2**ADDR_W.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH; 5..7 illegal.
req_funct3  in  3  funct3 field.
req_funct7  in  7  funct7 field; used by R and by I-ALU shifts.
req_rd  in  5  destination register.
req_rs1  in  5  source register 1.
req_rs2  in  5  source register 2.
req_imm  in  13  signed immediate, two's complement.
finish  in  1  end of program; level-sampled in IDLE.
restart  in  1  synchronous clear back to an empty program.
imem_we  out  1  write strobe.
imem_addr  out  ADDR_W  word address.
imem_wdata  out  32  encoded instruction.
count  out  ADDR_W+1  number of words written.
full  out  1  count == MEM_WORDS.
err  out  1  sticky; set by any rejected request.
done  out  1  program closed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - imem_we, imem_addr, imem_wdata, count, err, done all 0.
  - full = 0.
  - req_ready is 0 while rst_n is low.
- States:
  - IDLE: req_ready = !full.
    - Handshake (req_valid & req_ready): latch the encoded word, go to WRITE.
    - Illegal request: set err, stay in IDLE, write nothing.
    - finish with no handshake: go to DONE.
    - If req_valid and finish are both high, the request wins; finish is re-sampled on a later IDLE cycle.
  - WRITE: lasts exactly 1 cycle.
    - imem_we = 1, imem_addr = count[ADDR_W-1:0], imem_wdata = latched word.
    - req_ready = 0.
    - Next state IDLE; count increments at the end of the cycle.
  - DONE: done = 1, req_ready = 0. Stays until restart or reset.
- restart is legal in any state and has priority over everything else. Next cycle: state IDLE, count 0, err 0, done 0, imem_we 0.
- Throughput: one instruction every 2 cycles. Latency: handshake edge to imem_we high is 1 cycle.
- Encoding, with opcode in bits [6:0]:
  - R: funct7 | rs2 | rs1 | f3 | rd | 0110011.
  - I-ALU: imm[11:0] | rs1 | f3 | rd | 0010011.
    - For f3 = 001 or 101: bits [31:25] = funct7, bits [24:20] = imm[4:0].
  - LOAD: imm[11:0] | rs1 | f3 | rd | 0000011.
  - STORE: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | 0100011.
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | 1100011.
- Legality (illegal means the request is accepted and dropped, err is set, count is unchanged):
  - Class 5..7 is illegal.
  - I-ALU, LOAD and STORE imm outside -2048..2047 is illegal.
  - Shift imm outside 0..31 is illegal.
  - BRANCH imm odd is illegal.
  - 13-bit imm covers the full branch range, so branch range needs no extra check.
- full: asserted in the cycle after the WRITE that makes count == MEM_WORDS. From then on req_ready = 0 and finish is still honoured. Addresses never wrap.
- Reset mid-WRITE: the write is aborted combinationally (imem_we drops with rst_n) and count is not incremented.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants OPC_R=0110011, OPC_I=0010011, OPC_LOAD=0000011, OPC_STORE=0100011, OPC_BRANCH=1100011.
  - req_class encodings.
  - State enum IDLE/WRITE/DONE.
- One combinational sub-module, rv_inst_encode: inputs are the request fields; outputs are word[31:0] and illegal. The FSM, counter and handshake stay in the top.

Test Plan:
- R, f3=0, f7=0, rd=3, rs1=1, rs2=2 -> one cycle later imem_we=1, addr 0, wdata 0x002081B3; count=1.
- I-ALU, rd=5, rs1=0, imm=-1 then STORE, f3=010, rs1=1, rs2=2, imm=8 -> 0xFFF00293 at addr 0, then 0x0020A423 at addr 1.
- BRANCH, f3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. BRANCH with imm=3 -> err=1, no imem_we, count unchanged.
- I-ALU with imm=2048 -> err=1, no write. Then restart -> err=0, count=0.
- MEM_WORDS=4: five back-to-back valid requests -> 4 writes at addr 0..3, full=1, req_ready=0, fifth request stalls. Then finish -> done=1.
- rst_n low during a WRITE cycle -> imem_we drops immediately; after release count=0, state IDLE, req_ready=1.

Source files
------------

// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader:
// opcodes, request classes, loader states and an immediate-range helper.
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } req_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A 13-bit value fits a signed 12-bit field when its top two bits agree.
  function automatic logic fits_simm12(input logic signed [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Request handshake and instruction-memory write port of the loader.
// master = loader front end / memory side, slave = the loader itself.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_class;
  logic [2:0]         req_funct3;
  logic [6:0]         req_funct7;
  logic [4:0]         req_rd;
  logic [4:0]         req_rs1;
  logic [4:0]         req_rs2;
  logic signed [12:0] req_imm;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [31:0]        imem_wdata;

  modport master (
    output req_valid, req_class, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_class, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader_encode.sv
// Combinational RV32I field packer: turns one request into a 32-bit word
// and flags requests whose class or immediate cannot be encoded.
module rv_inst_encode
  import rv_pkg::*;
(
  input  logic [2:0]         req_class_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic signed [12:0] imm_i,
  output logic [31:0]        word_o,
  output logic               illegal_o
);

  logic is_shift;
  assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (req_class_i)
      CLS_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
      CLS_I: begin
        // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
        if (is_shift) begin
          word_o    = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_I};
          illegal_o = (imm_i[12:5] != 8'd0);
        end else begin
          word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_I};
          illegal_o = !fits_simm12(imm_i);
        end
      end
      CLS_LOAD: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
        illegal_o = !fits_simm12(imm_i);
      end
      CLS_STORE: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
        illegal_o = !fits_simm12(imm_i);
      end
      CLS_BRANCH: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        illegal_o = imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Instruction loader: accepts encode requests, writes one word per accepted
// request into imem sequentially, tracks count/full/err and program closure.
module inst_encoder_loader
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_encoder_loader_if.slave bus,
  input  logic                 finish,
  input  logic                 restart,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 err,
  output logic                 done
);

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;
  logic [31:0]     word_q;
  logic            load_word;
  logic [31:0]     enc_word;
  logic            enc_illegal;
  logic            accept;

  rv_inst_encode u_encode (
    .req_class_i (bus.req_class),
    .funct3_i    (bus.req_funct3),
    .funct7_i    (bus.req_funct7),
    .rd_i        (bus.req_rd),
    .rs1_i       (bus.req_rs1),
    .rs2_i       (bus.req_rs2),
    .imm_i       (bus.req_imm),
    .word_o      (enc_word),
    .illegal_o   (enc_illegal)
  );

  assign full          = (count_q == (ADDR_W+1)'(MEM_WORDS));
  // rst_n gating keeps ready low and aborts an in-flight write during reset.
  assign bus.req_ready = rst_n && (state_q == IDLE) && !full;
  assign bus.imem_we   = rst_n && (state_q == WRITE);
  assign bus.imem_addr = count_q[ADDR_W-1:0];
  assign bus.imem_wdata = bus.imem_we ? word_q : 32'd0;
  assign accept        = bus.req_valid && bus.req_ready;
  assign count         = count_q;
  assign err           = err_q;
  assign done          = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    load_word = 1'b0;
    if (restart) begin
      state_d = IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A request beats finish; finish is only seen without a handshake.
          if (accept) begin
            if (enc_illegal) begin
              err_d = 1'b1;
            end else begin
              state_d   = WRITE;
              load_word = 1'b1;
            end
          end else if (finish) begin
            state_d = DONE;
          end
        end
        WRITE: begin
          state_d = IDLE;
          count_d = count_q + (ADDR_W+1)'(1);
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_word) word_q <= enc_word;
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized and directed bench for inst_encoder_loader with an
// instruction-level reference model and a per-cycle output comparator.
module tb_inst_encoder_loader;
  localparam int ADDR_W = 6;
  localparam int MEM    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            finish, restart;
  logic [ADDR_W:0] count;
  logic            full, err, done;

  inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .finish  (finish),
    .restart (restart),
    .count   (count),
    .full    (full),
    .err     (err),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding straight from the field layout, using integer arithmetic.
  function automatic void model_enc(input int cls, input int f3, input int f7,
                                    input int rd, input int rs1, input int rs2,
                                    input int imm, output logic [31:0] w, output bit ok);
    int base, v;
    base = (rs1 << 15) | (f3 << 12);
    v    = 0;
    ok   = 1'b1;
    case (cls)
      0: v = (f7 << 25) | (rs2 << 20) | base | (rd << 7) | 'h33;
      1: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (imm >= 0) && (imm <= 31);
          v  = (f7 << 25) | ((imm & 31) << 20) | base | (rd << 7) | 'h13;
        end else begin
          ok = (imm >= -2048) && (imm <= 2047);
          v  = ((imm & 'hFFF) << 20) | base | (rd << 7) | 'h13;
        end
      end
      2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        v  = ((imm & 'hFFF) << 20) | base | (rd << 7) | 'h03;
      end
      3: begin
        ok = (imm >= -2048) && (imm <= 2047);
        v  = (((imm >>> 5) & 'h7F) << 25) | (rs2 << 20) | base | ((imm & 31) << 7) | 'h23;
      end
      4: begin
        ok = (imm % 2) == 0;
        v  = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 63) << 25) | (rs2 << 20) | base |
             (((imm >>> 1) & 15) << 8) | (((imm >>> 11) & 1) << 7) | 'h63;
      end
      default: ok = 1'b0;
    endcase
    w = v;
  endfunction

  // Reference state: words written, sticky error, closed flag, pending write.
  int          m_cnt = 0;
  bit          m_err = 0, m_done = 0, m_pend = 0;
  logic [31:0] m_word = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] w;
    bit          ok;
    if (!rst_n) begin
      m_cnt <= 0; m_err <= 0; m_done <= 0; m_pend <= 0;
    end else if (restart) begin
      m_cnt <= 0; m_err <= 0; m_done <= 0; m_pend <= 0;
    end else if (m_pend) begin
      m_cnt  <= m_cnt + 1;
      m_pend <= 0;
    end else if (!m_done) begin
      if (bus.req_valid && m_cnt < MEM) begin
        model_enc(int'(bus.req_class), int'(bus.req_funct3), int'(bus.req_funct7),
                  int'(bus.req_rd), int'(bus.req_rs1), int'(bus.req_rs2),
                  int'(bus.req_imm), w, ok);
        if (ok) begin
          m_pend <= 1;
          m_word <= w;
        end else begin
          m_err <= 1;
        end
      end else if (finish) begin
        m_done <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_ready", 32'(bus.req_ready), 32'(rst_n && !m_pend && !m_done && m_cnt < MEM));
    chk("cmp_we",    32'(bus.imem_we),   32'(rst_n && m_pend));
    chk("cmp_count", 32'(count),         32'(m_cnt));
    chk("cmp_full",  32'(full),          32'(m_cnt == MEM));
    chk("cmp_err",   32'(err),           32'(m_err));
    chk("cmp_done",  32'(done),          32'(m_done));
    if (rst_n && m_pend) begin
      chk("cmp_addr",  32'(bus.imem_addr), 32'(m_cnt));
      chk("cmp_wdata", bus.imem_wdata,     m_word);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int cls, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input int imm);
    bus.req_class  = 3'(cls);
    bus.req_funct3 = 3'(f3);
    bus.req_funct7 = 7'(f7);
    bus.req_rd     = 5'(rd);
    bus.req_rs1    = 5'(rs1);
    bus.req_rs2    = 5'(rs2);
    bus.req_imm    = 13'(imm);
    bus.req_valid  = 1'b1;
  endtask

  task automatic send_chk(input string name, input int cls, input int f3, input int f7,
                          input int rd, input int rs1, input int rs2, input int imm,
                          input logic [31:0] exp_w, input int exp_addr);
    set_req(cls, f3, f7, rd, rs1, rs2, imm);
    tick();
    bus.req_valid = 1'b0;
    chk({name, "_we"},    32'(bus.imem_we), 32'd1);
    chk({name, "_addr"},  32'(bus.imem_addr), 32'(exp_addr));
    chk({name, "_wdata"}, bus.imem_wdata, exp_w);
    tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    bit          ok;
    int          nw;
    int          imm_pick [8] = '{-2048, -2049, 2047, 2048, 31, 32, -1, 0};

    rst_n = 1'b0; finish = 1'b0; restart = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;

    model_enc(0, 0, 0, 3, 1, 2, 0, w, ok);   chk("model_r", w, 32'h002081B3);
    model_enc(1, 0, 0, 5, 0, 0, -1, w, ok);  chk("model_i", w, 32'hFFF00293);
    model_enc(3, 2, 0, 0, 1, 2, 8, w, ok);   chk("model_s", w, 32'h0020A423);
    model_enc(4, 0, 0, 0, 1, 2, -4, w, ok);  chk("model_b", w, 32'hFE208EE3);
    model_enc(4, 0, 0, 0, 1, 2, 3, w, ok);   chk("model_b_odd", 32'(ok), 32'd0);
    model_enc(1, 0, 0, 0, 0, 0, 2048, w, ok); chk("model_i_rng", 32'(ok), 32'd0);

    #2;
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, full, err, done}, 32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    send_chk("r_word", 0, 0, 0, 3, 1, 2, 0, 32'h002081B3, 0);
    chk("r_count", 32'(count), 32'd1);
    pulse_restart();
    chk("restart_count", 32'(count), 32'd0);

    send_chk("i_word", 1, 0, 0, 5, 0, 0, -1, 32'hFFF00293, 0);
    send_chk("s_word", 3, 2, 0, 0, 1, 2, 8, 32'h0020A423, 1);
    send_chk("b_word", 4, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 2);
    chk("b_count", 32'(count), 32'd3);

    set_req(4, 0, 0, 0, 1, 2, 3);
    tick();
    bus.req_valid = 1'b0;
    chk("b_odd_we", 32'(bus.imem_we), 32'd0);
    chk("b_odd_err", 32'(err), 32'd1);
    chk("b_odd_count", 32'(count), 32'd3);

    pulse_restart();
    set_req(1, 0, 0, 1, 1, 0, 2048);
    tick();
    bus.req_valid = 1'b0;
    chk("i_rng_we", 32'(bus.imem_we), 32'd0);
    chk("i_rng_err", 32'(err), 32'd1);
    chk("i_rng_count", 32'(count), 32'd0);
    pulse_restart();
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_count2", 32'(count), 32'd0);

    // Fill the memory with requests held valid back to back.
    nw = 0;
    set_req(0, 0, 0, 7, 4, 6, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.imem_we) begin
        chk("fill_addr", 32'(bus.imem_addr), 32'(nw));
        nw++;
      end
    end
    chk("fill_writes", 32'(nw), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(bus.req_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    bus.req_valid = 1'b0;
    chk("fill_done", 32'(done), 32'd1);
    pulse_restart();

    // Reset arriving during a write cycle.
    set_req(0, 0, 0, 3, 1, 2, 0);
    tick();
    bus.req_valid = 1'b0;
    chk("mid_we_before", 32'(bus.imem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we_drop", 32'(bus.imem_we), 32'd0);
    chk("mid_ready", 32'(bus.req_ready), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_ready_after", 32'(bus.req_ready), 32'd1);
    chk("mid_done_after", 32'(done), 32'd0);

    for (int i = 0; i < 800; i++) begin
      int c, imm;
      c = int'($urandom_range(0, 11));
      case ($urandom_range(0, 2))
        0:       imm = int'($urandom_range(0, 48)) - 8;
        1:       imm = int'($urandom_range(0, 8191)) - 4096;
        default: imm = imm_pick[$urandom_range(0, 7)];
      endcase
      set_req(c > 7 ? c - 8 : c, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), imm);
      bus.req_valid = ($urandom_range(0, 2) != 0);
      restart = ($urandom_range(0, 15) == 0);
      finish  = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.req_valid = 1'b0;
    restart = 1'b0;
    finish = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
